// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: VGA scan-out fetches take priority and the CPU gets the leftover cycles.
// Fetched words are unpacked into pixels, with the syncs delayed so they stay aligned with pixel data.
module vga_fb_arbiter #(
    parameter int PIXEL_WIDTH  = 640,
    parameter int PIXEL_HEIGHT = 480,
    parameter int PIXEL_BITS   = 8,
    parameter int PX_PER_WORD  = 4,
    localparam int WORD_W      = PIXEL_BITS * PX_PER_WORD,
    localparam int WPL         = PIXEL_WIDTH / PX_PER_WORD,
    localparam int FB_WORDS    = WPL * PIXEL_HEIGHT,
    localparam int FB_ADDR_W   = $clog2(FB_WORDS),
    localparam int XW          = $clog2(PIXEL_WIDTH),
    localparam int YW          = $clog2(PIXEL_HEIGHT)
) (
    input  logic                  pxclk,
    input  logic                  rst_n,
    input  logic [XW-1:0]         xaddr,
    input  logic [YW-1:0]         yaddr,
    input  logic                  addr_valid,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    output logic                  fb_en,
    output logic                  fb_we,
    output logic [FB_ADDR_W-1:0]  fb_addr,
    output logic [WORD_W-1:0]     fb_wdata,
    input  logic [WORD_W-1:0]     fb_rdata,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [FB_ADDR_W-1:0]  cpu_addr,
    input  logic [WORD_W-1:0]     cpu_wdata,
    output logic                  cpu_ready,
    output logic                  cpu_rvalid,
    output logic [WORD_W-1:0]     cpu_rdata,
    output logic [PIXEL_BITS-1:0] pixel,
    output logic                  pixel_valid,
    output logic                  hsync,
    output logic                  vsync
);
    localparam int OFF_W = $clog2(PX_PER_WORD);

    typedef enum logic {IDLE, RD_WAIT} state_t;
    state_t state, state_nxt;

    logic [OFF_W-1:0]     xoff;
    logic                 vga_slot;
    logic [FB_ADDR_W-1:0] vga_addr;
    logic                 cpu_in_range;
    logic                 rd_in_range_q;

    assign xoff         = xaddr[OFF_W-1:0];
    assign vga_slot     = addr_valid && (xoff == '0);
    assign vga_addr     = FB_ADDR_W'(yaddr) * FB_ADDR_W'(WPL) + FB_ADDR_W'(xaddr >> OFF_W);
    assign cpu_in_range = cpu_addr < FB_ADDR_W'(FB_WORDS);

    always_ff @(posedge pxclk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cpu_ready && !cpu_we) state_nxt = RD_WAIT;
            RD_WAIT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // VGA slot wins the RAM port outright; the CPU only gets it from IDLE.
    always_comb begin
        cpu_ready = 1'b0;
        fb_en     = 1'b0;
        fb_we     = 1'b0;
        fb_addr   = '0;
        fb_wdata  = '0;
        if (vga_slot) begin
            fb_en   = 1'b1;
            fb_addr = vga_addr;
        end else if (state == IDLE && cpu_req) begin
            cpu_ready = 1'b1;
            if (cpu_in_range) begin
                fb_en    = 1'b1;
                fb_we    = cpu_we;
                fb_addr  = cpu_addr;
                fb_wdata = cpu_wdata;
            end
        end
    end

    always_ff @(posedge pxclk or negedge rst_n) begin
        if (!rst_n) begin
            rd_in_range_q <= 1'b0;
            cpu_rvalid    <= 1'b0;
            cpu_rdata     <= '0;
        end else begin
            if (cpu_ready && !cpu_we) rd_in_range_q <= cpu_in_range;
            cpu_rvalid <= (state == RD_WAIT);
            if (state == RD_WAIT) cpu_rdata <= rd_in_range_q ? fb_rdata : '0;
        end
    end

    logic [OFF_W-1:0]  xoff_d1;
    logic              vga_slot_d1, addr_valid_d1, hsync_d1, vsync_d1;
    logic [WORD_W-1:0] word_buf, sel_word;

    // The first pixel of a word comes straight off the RAM; the rest come from word_buf.
    assign sel_word = (xoff_d1 == '0) ? fb_rdata : word_buf;

    always_ff @(posedge pxclk or negedge rst_n) begin
        if (!rst_n) begin
            xoff_d1       <= '0;
            vga_slot_d1   <= 1'b0;
            addr_valid_d1 <= 1'b0;
            hsync_d1      <= 1'b0;
            vsync_d1      <= 1'b0;
            word_buf      <= '0;
            pixel         <= '0;
            pixel_valid   <= 1'b0;
            hsync         <= 1'b0;
            vsync         <= 1'b0;
        end else begin
            xoff_d1       <= xoff;
            vga_slot_d1   <= vga_slot;
            addr_valid_d1 <= addr_valid;
            hsync_d1      <= hsync_in;
            vsync_d1      <= vsync_in;
            if (vga_slot_d1) word_buf <= fb_rdata;
            pixel         <= addr_valid_d1 ? sel_word[xoff_d1*PIXEL_BITS +: PIXEL_BITS] : '0;
            pixel_valid   <= addr_valid_d1;
            hsync         <= hsync_d1;
            vsync         <= vsync_d1;
        end
    end
endmodule
